// File: rtl/key_request_latch.sv
// Conditions 8 raw key lines (2-flop sync + per-line debounce) and latches each
// debounced press into a sticky pending vector feeding the priority encoder.
module key_request_latch #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       clr_overrun,
    output logic [7:0] pending,
    output logic       any_pending,
    output logic [7:0] key_level,
    output logic       overrun
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       db_state;
    logic [7:0]       db_next;
    logic [CNT_W-1:0] cnt      [8];
    logic [CNT_W-1:0] cnt_next [8];
    logic [7:0]       press;
    logic [7:0]       clr_mask;
    logic [7:0]       pending_next;
    logic             overrun_next;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            db_next[i]  = db_state[i];
            cnt_next[i] = cnt[i];
            if (s2[i] == db_state[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_next[i]  = s2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // A set on the same edge as a clear of that bit wins, so no press is lost.
    always_comb begin
        press        = db_next & ~db_state;
        clr_mask     = ack ? (8'h01 << ack_idx) : 8'h00;
        pending_next = (pending & ~clr_mask) | press;
        overrun_next = (overrun & ~clr_overrun) | (|(press & pending & ~clr_mask));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            db_state <= '0;
            pending  <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= key_in;
            s2       <= s1;
            db_state <= db_next;
            pending  <= pending_next;
            overrun  <= overrun_next;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign key_level   = db_state;
    assign any_pending = |pending;

endmodule
